// File: rtl/matmux_seq.sv
// Time-multiplexed affine matrix-vector sequencer: result[j] = b[j] + sum_i matrix[i][j]*vector[i] on one shared MAC.
// Define MATMUX_SEQ_SAT_EN to saturate each result to W bits instead of wrapping.
module matmux_seq #(
  parameter int W     = 32,
  parameter int N_IN  = 3,
  parameter int N_OUT = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [W-1:0]      in_data,
  input  logic                     reuse_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [W-1:0]      out_data,
  output logic [$clog2(N_OUT)-1:0] out_idx,
  output logic                     out_last,
  output logic                     busy
);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + $clog2(N_IN + 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  localparam logic [2:0] S_LOAD_W = 3'd0;
  localparam logic [2:0] S_LOAD_V = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [JW-1:0] oidx_q, oidx_d;
  logic          wvalid_q, wvalid_d;
  logic          in_ready_q, out_valid_q, busy_q;
  logic          in_acc, out_acc;

  logic signed [W-1:0]  m_q [N_IN][N_OUT];
  logic signed [W-1:0]  v_q [N_IN];
  logic signed [W-1:0]  b_q [N_OUT];
  logic signed [W-1:0]  res_q [N_OUT];
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [PW-1:0] prod;

  function automatic logic signed [W-1:0] fmt_result(input logic signed [AW-1:0] a);
`ifdef MATMUX_SEQ_SAT_EN
    logic signed [AW-1:0] hi, lo;
    hi = AW'({1'b0, {(W-1){1'b1}}});
    lo = ~hi;
    if (a > hi)      fmt_result = hi[W-1:0];
    else if (a < lo) fmt_result = lo[W-1:0];
    else             fmt_result = a[W-1:0];
`else
    fmt_result = W'(a);
`endif
  endfunction

  assign in_acc = in_valid && in_ready_q;
  assign out_acc = out_valid_q && out_ready;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    oidx_d   = oidx_q;
    wvalid_d = wvalid_q;
    case (state_q)
      // Matrix arrives row-major: j inner, i outer.
      S_LOAD_W: if (in_acc) begin
        if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == I_LAST) begin
            i_d      = '0;
            state_d  = S_LOAD_V;
            wvalid_d = 1'b1;
          end else i_d = i_q + 1'b1;
        end else j_d = j_q + 1'b1;
      end
      S_LOAD_V: if (in_acc) begin
        if (i_q == I_LAST) begin
          i_d     = '0;
          state_d = S_LOAD_B;
        end else i_d = i_q + 1'b1;
      end
      S_LOAD_B: if (in_acc) begin
        if (j_q == J_LAST) begin
          j_d     = '0;
          state_d = S_CALC;
        end else j_d = j_q + 1'b1;
      end
      // Compute walks j outer, i inner, one MAC per cycle.
      S_CALC: begin
        if (i_q == I_LAST) begin
          i_d = '0;
          if (j_q == J_LAST) begin
            j_d     = '0;
            state_d = S_OUT;
          end else j_d = j_q + 1'b1;
        end else i_d = i_q + 1'b1;
      end
      S_OUT: if (out_acc) begin
        if (oidx_q == J_LAST) begin
          oidx_d  = '0;
          state_d = (reuse_w && wvalid_q) ? S_LOAD_V : S_LOAD_W;
        end else oidx_d = oidx_q + 1'b1;
      end
      default: state_d = S_LOAD_W;
    endcase
  end

  // Stage boundary: control registers; status outputs follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD_W;
      i_q         <= '0;
      j_q         <= '0;
      oidx_q      <= '0;
      wvalid_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      oidx_q      <= oidx_d;
      wvalid_q    <= wvalid_d;
      in_ready_q  <= (state_d == S_LOAD_W) || (state_d == S_LOAD_V) || (state_d == S_LOAD_B);
      out_valid_q <= (state_d == S_OUT);
      busy_q      <= (state_d == S_CALC) || (state_d == S_OUT);
    end
  end

  assign prod  = PW'(m_q[i_q][j_q]) * PW'(v_q[i_q]);
  assign acc_d = ((i_q == '0) ? AW'(b_q[j_q]) : acc_q) + AW'(prod);

  // Stage boundary: operand storage, accumulator and result buffer (no reset).
  always_ff @(posedge clk) begin
    if (in_acc) begin
      case (state_q)
        S_LOAD_W: m_q[i_q][j_q] <= in_data;
        S_LOAD_V: v_q[i_q]      <= in_data;
        S_LOAD_B: b_q[j_q]      <= in_data;
        default: ;
      endcase
    end
    if (state_q == S_CALC) begin
      acc_q <= acc_d;
      if (i_q == I_LAST) res_q[j_q] <= fmt_result(acc_d);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? res_q[oidx_q] : '0;
  assign out_idx   = oidx_q;
  assign out_last  = out_valid_q && (oidx_q == J_LAST);
  assign busy      = busy_q;
endmodule
